// File: rtl/sobel_conv.sv
// Sobel gradient-magnitude stage fed by the 3x3 line-buffer window.
// Latency: 2 cycles from win_valid to pixel_valid_out; one window per cycle.
// Backpressure: none; free-running pipeline, gaps in win_valid become gaps in pixel_valid_out.
//
// Ports:
//   clk, rst          - clock and asynchronous active-high reset
//   frame_start       - clears the column/row position before the first window of a frame
//   win_valid         - window_in holds a window to be consumed this cycle
//   window_in[j][k]   - j=0 newest (bottom) line, j=2 top; k=0 newest (right) pixel, k=2 left
//   thresh_en, thresh - binary-output mode select and edge threshold (sampled at stage 2)
//   pixel_out         - saturated magnitude, or 0/max in binary mode; 0 for border windows
//   pixel_edge_out    - magnitude >= thresh (0 for border windows)
//   pixel_valid_out   - outputs are valid this cycle
module sobel_conv #(
    parameter int DATA_WIDTH = 12,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    input  logic                  win_valid,
    input  logic [DATA_WIDTH-1:0] window_in [2:0][2:0],
    input  logic                  thresh_en,
    input  logic [DATA_WIDTH-1:0] thresh,
    output logic [DATA_WIDTH-1:0] pixel_out,
    output logic                  pixel_edge_out,
    output logic                  pixel_valid_out
);

    // Gradient width: 4x max pixel plus sign fits in DATA_WIDTH+4 bits (16 for 12-bit pixels).
    localparam int GW = DATA_WIDTH + 4;
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [DATA_WIDTH-1:0] PIX_MAX = '1;

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [CW-1:0] cur_col;
    logic [RW-1:0] cur_row;
    logic          border_now;

    logic signed [GW-1:0] gx_c;
    logic signed [GW-1:0] gy_c;
    logic signed [GW-1:0] gx1;
    logic signed [GW-1:0] gy1;
    logic                 border1;
    logic                 vld1;

    logic [GW-1:0]         abs_x;
    logic [GW-1:0]         abs_y;
    logic [GW-1:0]         mag;
    logic [DATA_WIDTH-1:0] sat;
    logic                  is_edge;

    function automatic logic signed [GW-1:0] ext(input logic [DATA_WIDTH-1:0] p);
        return $signed({{(GW-DATA_WIDTH){1'b0}}, p});
    endfunction

    // A window arriving together with frame_start is position (0,0).
    assign cur_col    = frame_start ? '0 : col;
    assign cur_row    = frame_start ? '0 : row;
    assign border_now = (cur_col < CW'(2)) || (cur_row < RW'(2));

    assign gx_c = (ext(window_in[0][0]) + (ext(window_in[1][0]) <<< 1) + ext(window_in[2][0]))
                - (ext(window_in[0][2]) + (ext(window_in[1][2]) <<< 1) + ext(window_in[2][2]));
    assign gy_c = (ext(window_in[0][0]) + (ext(window_in[0][1]) <<< 1) + ext(window_in[0][2]))
                - (ext(window_in[2][0]) + (ext(window_in[2][1]) <<< 1) + ext(window_in[2][2]));

    // Position counters advance only on accepted windows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (frame_start) begin
            col <= win_valid ? CW'(1) : '0;
            row <= '0;
        end else if (win_valid) begin
            if (col == CW'(IMG_WIDTH - 1)) begin
                col <= '0;
                row <= (row == RW'(IMG_HEIGHT - 1)) ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Stage 1: gradients and border flag; data holds while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld1    <= 1'b0;
            gx1     <= '0;
            gy1     <= '0;
            border1 <= 1'b0;
        end else begin
            vld1 <= win_valid;
            if (win_valid) begin
                gx1     <= gx_c;
                gy1     <= gy_c;
                border1 <= border_now;
            end
        end
    end

    // Stage 2 combinational: |Gx|+|Gy| never overflows GW bits (max 32760).
    assign abs_x   = gx1[GW-1] ? $unsigned(-gx1) : $unsigned(gx1);
    assign abs_y   = gy1[GW-1] ? $unsigned(-gy1) : $unsigned(gy1);
    assign mag     = abs_x + abs_y;
    assign sat     = (mag > GW'(PIX_MAX)) ? PIX_MAX : mag[DATA_WIDTH-1:0];
    assign is_edge = (sat >= thresh);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pixel_valid_out <= 1'b0;
            pixel_out       <= '0;
            pixel_edge_out  <= 1'b0;
        end else begin
            pixel_valid_out <= vld1;
            if (vld1) begin
                pixel_edge_out <= !border1 && is_edge;
                if (border1)
                    pixel_out <= '0;
                else if (thresh_en)
                    pixel_out <= is_edge ? PIX_MAX : '0;
                else
                    pixel_out <= sat;
            end
        end
    end

endmodule

// File: tb/tb_sobel_conv.sv
// Self-checking bench for sobel_conv: directed cases plus randomized windows
// checked against an arithmetic reference model with a linear pixel index.
module tb_sobel_conv;

    localparam int IMG_W = 640;
    localparam int IMG_H = 480;

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic        win_valid;
    logic [11:0] win [2:0][2:0];
    logic        thresh_en;
    logic [11:0] thresh;
    logic [11:0] pixel_out;
    logic        pixel_edge_out;
    logic        pixel_valid_out;

    int total = 0;
    int bad   = 0;

    // Model state: linear index of the next window within the frame.
    int idx = 0;
    // Expectation for the window currently sitting in the DUT's first stage.
    logic        s1_v = 1'b0;
    logic [11:0] s1_p = '0;
    logic        s1_e = 1'b0;

    logic        rec = 1'b0;
    logic [11:0] obs_q [$];

    sobel_conv #(.DATA_WIDTH(12), .IMG_WIDTH(IMG_W), .IMG_HEIGHT(IMG_H)) dut (
        .clk             (clk),
        .rst             (rst),
        .frame_start     (frame_start),
        .win_valid       (win_valid),
        .window_in       (win),
        .thresh_en       (thresh_en),
        .thresh          (thresh),
        .pixel_out       (pixel_out),
        .pixel_edge_out  (pixel_edge_out),
        .pixel_valid_out (pixel_valid_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int px(input int j, input int k);
        return int'(win[j][k]);
    endfunction

    // One clock: present inputs, predict this window, then check what leaves the DUT.
    task automatic step(input logic v, input logic fs);
        int c, r, gx, gy, mag, sat;
        logic bord, e;
        logic [11:0] p;
        win_valid   = v;
        frame_start = fs;
        if (fs) idx = 0;
        c    = idx % IMG_W;
        r    = idx / IMG_W;
        bord = (c < 2) || (r < 2);
        gx   = (px(0,0) + 2*px(1,0) + px(2,0)) - (px(0,2) + 2*px(1,2) + px(2,2));
        gy   = (px(0,0) + 2*px(0,1) + px(0,2)) - (px(2,0) + 2*px(2,1) + px(2,2));
        mag  = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        sat  = (mag > 4095) ? 4095 : mag;
        e    = !bord && (sat >= int'(thresh));
        if (bord)           p = 12'd0;
        else if (thresh_en) p = e ? 12'd4095 : 12'd0;
        else                p = 12'(sat);
        if (v) idx = (idx + 1) % (IMG_W * IMG_H);
        @(posedge clk);
        #1;
        check("valid", 32'(pixel_valid_out), 32'(s1_v));
        if (s1_v) begin
            check("pixel", 32'(pixel_out), 32'(s1_p));
            check("edge", 32'(pixel_edge_out), 32'(s1_e));
            if (rec) obs_q.push_back(pixel_out);
        end
        s1_v = v;
        s1_p = p;
        s1_e = e;
    endtask

    task automatic set_cols(input logic [11:0] left, input logic [11:0] mid, input logic [11:0] right);
        for (int j = 0; j < 3; j++) begin
            win[j][2] = left;
            win[j][1] = mid;
            win[j][0] = right;
        end
    endtask

    task automatic set_rand(input int amp);
        for (int j = 0; j < 3; j++)
            for (int k = 0; k < 3; k++)
                win[j][k] = 12'($urandom_range(0, amp));
    endtask

    // Single window at the current position, drained, with its output checked by name.
    task automatic directed(input string tag, input logic en, input logic [11:0] th,
                            input int exp_pix, input int exp_edge);
        thresh_en = en;
        thresh    = th;
        obs_q.delete();
        rec = 1'b1;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        rec = 1'b0;
        check({tag, "_count"}, 32'(obs_q.size()), 32'd1);
        if (obs_q.size() == 1) begin
            check({tag, "_pix"}, 32'(obs_q[0]), 32'(exp_pix));
            check({tag, "_edge"}, 32'(pixel_edge_out), 32'(exp_edge));
        end
    endtask

    initial begin
        int amp;
        rst         = 1'b1;
        frame_start = 1'b0;
        win_valid   = 1'b0;
        thresh_en   = 1'b0;
        thresh      = 12'd1;
        set_cols(12'd0, 12'd0, 12'd0);
        #12;
        check("rst_valid", 32'(pixel_valid_out), 32'd0);
        check("rst_pixel", 32'(pixel_out), 32'd0);
        check("rst_edge", 32'(pixel_edge_out), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Border and wrap: vertical edges across rows 0..2.
        set_cols(12'd0, 12'd2048, 12'd4095);
        obs_q.delete();
        rec = 1'b1;
        step(1'b1, 1'b1);
        for (int i = 1; i < 1283; i++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        rec = 1'b0;
        check("wrap_count", 32'(obs_q.size()), 32'd1283);
        if (obs_q.size() == 1283) begin
            check("row0_first", 32'(obs_q[0]), 32'd0);
            check("row0_last", 32'(obs_q[639]), 32'd0);
            check("row1_col0", 32'(obs_q[640]), 32'd0);
            check("row1_col1", 32'(obs_q[641]), 32'd0);
            check("row1_col2", 32'(obs_q[642]), 32'd0);
            check("row2_col1", 32'(obs_q[1281]), 32'd0);
            check("row2_col2", 32'(obs_q[1282]), 32'd4095);
        end

        // Directed cases at row 2, interior columns.
        set_cols(12'd100, 12'd100, 12'd100);
        directed("flat", 1'b0, 12'd1, 0, 0);
        directed("flat_th0", 1'b0, 12'd0, 0, 1);
        set_cols(12'd0, 12'd2048, 12'd4095);
        directed("vedge_mag", 1'b0, 12'd2000, 4095, 1);
        directed("vedge_bin", 1'b1, 12'd2000, 4095, 1);
        set_cols(12'd10, 12'd15, 12'd20);
        directed("small_t50", 1'b0, 12'd50, 40, 0);
        directed("small_t40", 1'b0, 12'd40, 40, 1);
        directed("small_bin", 1'b1, 12'd40, 4095, 1);
        directed("small_bin0", 1'b1, 12'd50, 0, 0);

        // Gap pattern 1,1,0,1.
        thresh_en = 1'b0;
        thresh    = 12'd100;
        set_rand(4095);
        step(1'b1, 1'b0);
        set_rand(255);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        set_rand(4095);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        // Reset with two windows in flight.
        set_rand(4095);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        win_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_valid", 32'(pixel_valid_out), 32'd0);
        check("midrst_pixel", 32'(pixel_out), 32'd0);
        check("midrst_edge", 32'(pixel_edge_out), 32'd0);
        @(posedge clk);
        #1;
        rst  = 1'b0;
        s1_v = 1'b0;
        idx  = 0;
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        // Randomized bursts; thresholds change only with the pipeline drained.
        for (int b = 0; b < 60; b++) begin
            thresh_en = 1'($urandom_range(0, 1));
            thresh    = ($urandom_range(0, 1) == 1) ? 12'($urandom_range(0, 4095))
                                                    : 12'($urandom_range(0, 300));
            for (int i = 0; i < 60; i++) begin
                case ($urandom_range(0, 2))
                    0:       amp = 15;
                    1:       amp = 255;
                    default: amp = 4095;
                endcase
                set_rand(amp);
                step(($urandom_range(0, 3) != 0), ($urandom_range(0, 2999) == 0));
            end
            frame_start = 1'b0;
            step(1'b0, 1'b0);
            step(1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
